// File: rtl/debug_frame_sequencer.sv
// Emits a fixed 31-byte ASCII snapshot of CPU/bus state over a byte valid/ready
// handshake, triggered by a halt rising edge or a dump request.
module debug_frame_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        dump_req,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        rd,
  input  logic        wr,
  input  logic        cs,
  input  logic [7:0]  opcode,
  input  logic [15:0] pc,
  input  logic [15:0] last_pc,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned LAST_IDX = 30;

  typedef enum logic [1:0] {IDLE, SEND, DONE, CAPTURE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               pending;
  logic               halt_d;
  logic               trig;
  logic               load;

  logic [15:0] snap_pc;
  logic [15:0] snap_last_pc;
  logic [7:0]  snap_opcode;
  logic [15:0] snap_addr;
  logic [7:0]  snap_data;
  logic        snap_rd;
  logic        snap_wr;
  logic        snap_cs;

  assign trig = (halt & ~halt_d) | dump_req;
  // A new frame starts either from IDLE on a trigger or from the queued-request capture cycle.
  assign load = ((state == IDLE) && trig) || (state == CAPTURE);

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      5'd0:  b = 8'h50;
      5'd1:  b = hex_char(snap_pc[15:12]);
      5'd2:  b = hex_char(snap_pc[11:8]);
      5'd3:  b = hex_char(snap_pc[7:4]);
      5'd4:  b = hex_char(snap_pc[3:0]);
      5'd5:  b = 8'h20;
      5'd6:  b = 8'h4C;
      5'd7:  b = hex_char(snap_last_pc[15:12]);
      5'd8:  b = hex_char(snap_last_pc[11:8]);
      5'd9:  b = hex_char(snap_last_pc[7:4]);
      5'd10: b = hex_char(snap_last_pc[3:0]);
      5'd11: b = 8'h20;
      5'd12: b = 8'h4F;
      5'd13: b = hex_char(snap_opcode[7:4]);
      5'd14: b = hex_char(snap_opcode[3:0]);
      5'd15: b = 8'h20;
      5'd16: b = 8'h41;
      5'd17: b = hex_char(snap_addr[15:12]);
      5'd18: b = hex_char(snap_addr[11:8]);
      5'd19: b = hex_char(snap_addr[7:4]);
      5'd20: b = hex_char(snap_addr[3:0]);
      5'd21: b = 8'h20;
      5'd22: b = 8'h44;
      5'd23: b = hex_char(snap_data[7:4]);
      5'd24: b = hex_char(snap_data[3:0]);
      5'd25: b = 8'h20;
      5'd26: b = snap_rd ? 8'h52 : 8'h2D;
      5'd27: b = snap_wr ? 8'h57 : 8'h2D;
      5'd28: b = snap_cs ? 8'h43 : 8'h2D;
      5'd29: b = 8'h0D;
      5'd30: b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Field snapshot; the frame never looks at the live probe inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pc      <= '0;
      snap_last_pc <= '0;
      snap_opcode  <= '0;
      snap_addr    <= '0;
      snap_data    <= '0;
      snap_rd      <= 1'b0;
      snap_wr      <= 1'b0;
      snap_cs      <= 1'b0;
    end else if (load) begin
      snap_pc      <= pc;
      snap_last_pc <= last_pc;
      snap_opcode  <= opcode;
      snap_addr    <= addr;
      snap_data    <= data;
      snap_rd      <= rd;
      snap_wr      <= wr;
      snap_cs      <= cs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      halt_d     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      halt_d     <= halt;
      frame_done <= 1'b0;
      if (load) begin
        idx      <= '0;
        tx_data  <= 8'h50;
        tx_valid <= 1'b1;
        busy     <= 1'b1;
        state    <= SEND;
      end
      case (state)
        SEND: begin
          if (trig) pending <= 1'b1;
          if (tx_ready) begin
            if (idx == IDX_W'(LAST_IDX)) begin
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx     <= idx + IDX_W'(1);
              tx_data <= frame_byte(idx + IDX_W'(1));
            end
          end
        end
        DONE: begin
          // A request arriving in this very cycle still counts as queued.
          if (pending || trig) begin
            pending <= 1'b1;
            state   <= CAPTURE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CAPTURE: pending <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_sequencer.sv
// Directed plus randomized checks of debug_frame_sequencer against a string-level frame model.
module tb_debug_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt, dump_req, rd, wr, cs, tx_ready;
  logic [15:0] addr, pc, last_pc;
  logic [7:0]  data, opcode;
  logic        tx_valid, busy, frame_done;
  logic [7:0]  tx_data;

  debug_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .dump_req(dump_req),
    .addr(addr), .data(data), .rd(rd), .wr(wr), .cs(cs), .opcode(opcode),
    .pc(pc), .last_pc(last_pc), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  byte unsigned rx_q[$];
  int fd_cnt = 0, busy_fall = 0, stall_err = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Byte collector and handshake-stability watcher.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !(tx_valid && tx_data == prev_data)) stall_err++;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (frame_done) fd_cnt++;
      if (prev_busy && !busy) busy_fall++;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_busy  = busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = (s[i] < 8'h20) ? {r, "."} : $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic chk_str(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, esc(obs), esc(exp));
    end
  endtask

  function automatic string hexs(input logic [15:0] v, input int n);
    string digits = "0123456789ABCDEF";
    string r = "";
    for (int i = n - 1; i >= 0; i--) r = $sformatf("%s%c", r, digits[v[4*i +: 4]]);
    return r;
  endfunction

  function automatic string model(input logic [15:0] p, input logic [15:0] l, input logic [7:0] o,
                                  input logic [15:0] a, input logic [7:0] d,
                                  input logic r, input logic w, input logic c);
    return $sformatf("P%s L%s O%s A%s D%s %s%s%s%c%c", hexs(p, 4), hexs(l, 4), hexs(16'(o), 2),
                     hexs(a, 4), hexs(16'(d), 2), r ? "R" : "-", w ? "W" : "-", c ? "C" : "-",
                     8'h0D, 8'h0A);
  endfunction

  function automatic string frame_at(input int base);
    string s = "";
    for (int i = base; i < base + 31 && i < rx_q.size(); i++) s = $sformatf("%s%c", s, rx_q[i]);
    return s;
  endfunction

  function automatic string live_model();
    return model(pc, last_pc, opcode, addr, data, rd, wr, cs);
  endfunction

  task automatic pulse_dump();
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk({tag, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic set_base_fields();
    pc = 16'hAAAA; last_pc = 16'h9999; opcode = 8'h99; addr = 16'h9999; data = 8'h99;
    rd = 1'b0; wr = 1'b0; cs = 1'b0;
  endtask

  initial begin
    string exp_s;
    int fd0, bf0, n0, n;
    reset_n = 1'b0; halt = 1'b0; dump_req = 1'b0; tx_ready = 1'b1;
    set_base_fields();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {tx_valid, busy, frame_done, tx_data}, 11'h000);

    // Scenario 1: halt rising edge, full-rate frame
    repeat (10) @(posedge clk);
    #1 halt = 1'b1;
    exp_s = live_model();
    fd0 = fd_cnt;
    @(negedge clk);
    chk("t1_pre_valid", 64'(tx_valid), 64'd0);
    @(negedge clk);
    chk("t1_latency", 64'(tx_valid), 64'd1);
    chk("t1_first_byte", 64'(tx_data), 64'h50);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (!tx_valid) n++;
    end
    chk("t1_gaps", 64'(n), 64'd0);
    @(negedge clk);
    chk("t1_done_cycle", {frame_done, tx_valid, busy}, 3'b101);
    @(negedge clk);
    chk("t1_idle", {frame_done, busy}, 2'b00);
    chk_str("t1_frame", frame_at(0), exp_s);
    chk("t1_fd_count", 64'(fd_cnt - fd0), 64'd1);

    // Scenario 2: snapshot isolation, then dump_req with rd/cs set
    halt = 1'b0;
    @(posedge clk); #1;
    rx_q.delete();
    exp_s = live_model();
    halt = 1'b1;
    @(posedge clk); #1;
    pc = 16'h1234;
    wait_idle("t2a", 100);
    chk_str("t2_snapshot", frame_at(0), exp_s);
    rd = 1'b1; cs = 1'b1;
    exp_s = live_model();
    pulse_dump();
    wait_idle("t2b", 100);
    chk_str("t2_rd_cs", frame_at(31), exp_s);

    // Scenario 3: backpressure pattern 1,0,0,1
    halt = 1'b0;
    set_base_fields();
    @(posedge clk); #1;
    rx_q.delete();
    exp_s = live_model();
    n0 = stall_err;
    pulse_dump();
    n = 0;
    while (busy && n < 400) begin
      tx_ready = (n % 4 == 0) || (n % 4 == 3);
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b1;
    chk("t3_timeout", 64'(busy), 64'd0);
    chk("t3_stable", 64'(stall_err - n0), 64'd0);
    chk("t3_count", 64'(rx_q.size()), 64'd31);
    chk_str("t3_frame", frame_at(0), exp_s);

    // Scenario 4: three requests mid-frame collapse into one follow-up frame
    rx_q.delete();
    fd0 = fd_cnt; bf0 = busy_fall;
    exp_s = live_model();
    pulse_dump();
    n = 0;
    while ((n < 20 || busy) && n < 300) begin
      dump_req = (n == 5) || (n == 10) || (n == 15);
      @(posedge clk); #1;
      n++;
    end
    dump_req = 1'b0;
    @(negedge clk);
    chk("t4_fd_count", 64'(fd_cnt - fd0), 64'd2);
    chk("t4_busy_falls", 64'(busy_fall - bf0), 64'd1);
    chk("t4_bytes", 64'(rx_q.size()), 64'd62);
    chk_str("t4_frame0", frame_at(0), exp_s);
    chk_str("t4_frame1", frame_at(31), exp_s);

    // Scenario 5: reset at byte index 12
    rx_q.delete();
    pulse_dump();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_valid && tx_data == 8'h4F) && n < 60);
    chk("t5_reach_idx12", 64'(tx_data), 64'h4F);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_drop", {tx_valid, busy}, 2'b00);
    @(posedge clk); #1 reset_n = 1'b1;
    n0 = rx_q.size(); fd0 = fd_cnt;
    repeat (40) @(negedge clk);
    chk("t5_no_resume", {32'(rx_q.size() - n0), 31'(fd_cnt - fd0), tx_valid}, 64'd0);

    // Scenario 6: halt high across reset release, then halt edge coincident with dump_req
    reset_n = 1'b0; halt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    rx_q.delete();
    exp_s = live_model();
    fd0 = fd_cnt;
    repeat (80) @(negedge clk);
    chk("t6_halt_at_release", 64'(fd_cnt - fd0), 64'd1);
    chk_str("t6_frame", frame_at(0), exp_s);
    halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fd0 = fd_cnt;
    halt = 1'b1;
    pulse_dump();
    repeat (80) @(negedge clk);
    chk("t6_coincident", 64'(fd_cnt - fd0), 64'd1);

    // Randomized fields and backpressure
    halt = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) begin
      pc = 16'($urandom); last_pc = 16'($urandom); opcode = 8'($urandom);
      addr = 16'($urandom); data = 8'($urandom);
      rd = 1'($urandom); wr = 1'($urandom); cs = 1'($urandom);
      rx_q.delete();
      exp_s = live_model();
      pulse_dump();
      pc = ~pc; data = ~data;
      n = 0;
      while (busy && n < 600) begin
        tx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      tx_ready = 1'b1;
      chk($sformatf("rand%0d_timeout", r), 64'(busy), 64'd0);
      chk_str($sformatf("rand%0d_frame", r), frame_at(0), exp_s);
    end
    chk("stall_stability", 64'(stall_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
